// File: rtl/prewitt_pkg.sv
// Shared widths, FSM state type and magnitude helper for the vertical-mask
// Prewitt streaming edge detector.
package prewitt_pkg;

  localparam int PIX_W = 8;
  localparam int SUM_W = PIX_W + 2;
  localparam int DIF_W = PIX_W + 3;

  localparam logic [PIX_W-1:0] PIX_MAX = '1;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // |d| saturated to the pixel range; -765..765 always fits DIF_W bits.
  function automatic logic [PIX_W-1:0] clamp_abs(input logic signed [DIF_W-1:0] d);
    logic [DIF_W-1:0] mag;
    mag = d[DIF_W-1] ? $unsigned(-d) : $unsigned(d);
    return (mag > DIF_W'(PIX_MAX)) ? PIX_MAX : mag[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/prewitt_line_buffer.sv
// One-row pixel delay line addressed by the column counter; the old entry is
// read and the new pixel written at the same address in the same cycle.
module prewitt_line_buffer
  import prewitt_pkg::*;
#(
  parameter int DEPTH  = 247,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              shift_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [PIX_W-1:0]  din,
  output logic [PIX_W-1:0]  dout
);

  logic [PIX_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (shift_en) begin
      mem_q[addr] <= din;
    end
  end

  assign dout = mem_q[addr];

endmodule

// File: rtl/prewitt_ver_stream.sv
// Streaming 3x3 Prewitt vertical-mask (column difference) edge detector with
// a zero border, valid/ready on both sides and one output per input pixel.
module prewitt_ver_stream
  import prewitt_pkg::*;
#(
  parameter int ROWS = 242,
  parameter int COLS = 247
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PIX_W-1:0] m_data,
  output logic             m_last
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam int FLS_W = $clog2(COLS + 2);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [FLS_W-1:0] FLS_LAST = FLS_W'(COLS);
  localparam logic [FLS_W-1:0] FLS_DONE = FLS_W'(COLS + 1);

  state_e                       state_q, state_d;
  logic [ROW_W-1:0]             row_q, row_d;
  logic [COL_W-1:0]             col_q, col_d;
  logic [FLS_W-1:0]             flush_cnt_q, flush_cnt_d;
  logic                         ready_en_q, ready_en_d;
  logic                         m_valid_q, m_valid_d;
  logic [PIX_W-1:0]             m_data_q, m_data_d;
  logic                         m_last_q, m_last_d;
  logic [2:0][PIX_W-1:0]        mid_q, mid_d;
  logic [2:0][PIX_W-1:0]        left_q, left_d;

  logic                         accept;
  logic [PIX_W-1:0]             lb0_out, lb1_out;
  logic [2:0][PIX_W-1:0]        right_col;
  logic [SUM_W-1:0]             right_sum, left_sum;
  logic signed [DIF_W-1:0]      diff;
  logic [PIX_W-1:0]             edge_mag;
  logic                         interior;
  logic                         last_pixel;
  logic                         fill_done;

  // lb0 yields row r-1 and lb1 row r-2 at the current column.
  prewitt_line_buffer #(
    .DEPTH  (COLS),
    .ADDR_W (COL_W)
  ) u_lb0 (
    .clk      (clk),
    .shift_en (accept),
    .addr     (col_q),
    .din      (s_data),
    .dout     (lb0_out)
  );

  prewitt_line_buffer #(
    .DEPTH  (COLS),
    .ADDR_W (COL_W)
  ) u_lb1 (
    .clk      (clk),
    .shift_en (accept),
    .addr     (col_q),
    .din      (lb0_out),
    .dout     (lb1_out)
  );

  assign right_col  = {s_data, lb0_out, lb1_out};
  assign right_sum  = SUM_W'(right_col[0]) + SUM_W'(right_col[1]) + SUM_W'(right_col[2]);
  assign left_sum   = SUM_W'(left_q[0]) + SUM_W'(left_q[1]) + SUM_W'(left_q[2]);
  assign diff       = $signed({1'b0, right_sum}) - $signed({1'b0, left_sum});
  assign edge_mag   = clamp_abs(diff);

  // The input at (r,c) completes the window centred on (r-1,c-1); with c==0
  // the pending output is the right border of the row above instead.
  assign interior   = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
  assign last_pixel = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign fill_done  = (row_q == ROW_W'(1)) && (col_q == '0);

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    flush_cnt_d = flush_cnt_q;
    ready_en_d  = 1'b1;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    mid_d       = mid_q;
    left_d      = left_q;
    s_ready     = 1'b0;

    case (state_q)
      FILL:    s_ready = ready_en_q;
      RUN:     s_ready = ready_en_q && (!m_valid_q || m_ready);
      default: s_ready = 1'b0;
    endcase

    accept = s_valid && s_ready;

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    if (accept) begin
      left_d = mid_q;
      mid_d  = right_col;
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    case (state_q)
      FILL: begin
        if (accept && fill_done) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          m_valid_d = 1'b1;
          m_data_d  = interior ? edge_mag : '0;
          m_last_d  = 1'b0;
          if (last_pixel) begin
            state_d     = FLUSH;
            flush_cnt_d = '0;
          end
        end
      end
      FLUSH: begin
        // Trailing border zeros, one per free slot in the output register.
        if ((!m_valid_q || m_ready) && (flush_cnt_q != FLS_DONE)) begin
          m_valid_d   = 1'b1;
          m_data_d    = '0;
          m_last_d    = (flush_cnt_q == FLS_LAST);
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
        if (m_valid_q && m_ready && m_last_q) begin
          state_d  = FILL;
          m_last_d = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      row_q       <= '0;
      col_q       <= '0;
      flush_cnt_q <= '0;
      ready_en_q  <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      mid_q       <= '0;
      left_q      <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      flush_cnt_q <= flush_cnt_d;
      ready_en_q  <= ready_en_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      mid_q       <= mid_d;
      left_q      <= left_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;

endmodule
